// File: rtl/encoder83_pkg.sv
// Shared constants and helpers for the 8-to-3 event encoder.
// Sizes of the request vector and of the code it is encoded to.
package encoder83_pkg;

  localparam int C_N = 8;
  localparam int C_W = 3;

  // One-hot mask of a request index.
  function automatic logic [C_N-1:0] onehot(input logic [C_W-1:0] idx);
    logic [C_N-1:0] one;
    one = {{(C_N-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Picks the next pending index, round-robin from ptr or lowest-first.
// Double-width masked priority encoder: upper copy catches the wrap-around.
module rr_pick8
  import encoder83_pkg::*;
(
  input  logic [C_N-1:0] pend_i,
  input  logic [C_W-1:0] ptr_i,
  input  logic           rr_en_i,
  output logic           any_o,
  output logic [C_W-1:0] idx_o
);

  logic [C_W-1:0]   base;
  logic [C_N-1:0]   keep;
  logic [2*C_N-1:0] dbl;

  // Lower copy keeps only bits at or above the search start.
  always_comb begin
    base = rr_en_i ? ptr_i : '0;
    keep = ~((C_N'(1) << base) - C_N'(1));
    dbl  = {pend_i, pend_i & keep};
  end

  // Lowest set bit of the doubled vector, folded back to 0..7.
  always_comb begin
    any_o = |pend_i;
    idx_o = '0;
    for (int i = 2*C_N-1; i >= 0; i--) begin
      if (dbl[i]) idx_o = C_W'(i);
    end
  end

endmodule

// File: rtl/encoder83_rr.sv
// Collects events on 8 request lines into a pending set and
// emits each as a 3-bit code over a valid/ready handshake.
module encoder83_rr
  import encoder83_pkg::*;
#(
  parameter logic P_EDGE = 1'b1,
  parameter logic P_RR   = 1'b1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [C_N-1:0] i_req,
  input  logic           i_opt,
  output logic           o_valid,
  output logic [C_W-1:0] o_code,
  input  logic           i_ready,
  output logic [C_N-1:0] o_pending,
  output logic           o_drop
);

  logic [C_N-1:0] req_q;
  logic           opt_q;
  logic [C_N-1:0] pend_q, pend_d;
  logic [C_W-1:0] code_q, code_d;
  logic           valid_q, valid_d;
  logic [C_W-1:0] ptr_q, ptr_d;
  logic           drop_q, drop_d;

  logic [C_N-1:0] e, e_prev, ev, claim;
  logic           load;
  logic           pick_any;
  logic [C_W-1:0] pick_idx;

  // Event detect; previous level reinterpreted with the current polarity.
  always_comb begin
    e      = i_opt ? ~i_req : i_req;
    e_prev = i_opt ? ~req_q : req_q;
    if (P_EDGE) begin
      ev = (i_opt != opt_q) ? '0 : (e & ~e_prev);
    end else begin
      ev = e;
    end
  end

  rr_pick8 u_pick (
    .pend_i  (pend_q),
    .ptr_i   (ptr_q),
    .rr_en_i (P_RR),
    .any_o   (pick_any),
    .idx_o   (pick_idx)
  );

  // Output load, claim, pending and pointer next state.
  always_comb begin
    load    = pick_any && (!valid_q || i_ready);
    claim   = load ? onehot(pick_idx) : '0;
    pend_d  = (pend_q & ~claim) | ev;
    drop_d  = P_EDGE && |(ev & pend_q & ~claim);
    code_d  = code_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (load) begin
      code_d  = pick_idx;
      valid_d = 1'b1;
      ptr_d   = pick_idx + C_W'(1);
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_q   <= '0;
      opt_q   <= 1'b0;
      pend_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      req_q   <= i_req;
      opt_q   <= i_opt;
      pend_q  <= pend_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      drop_q  <= drop_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_code    = code_q;
  assign o_pending = pend_q;
  assign o_drop    = drop_q;

endmodule

// File: tb/tb_encoder83_rr.sv
// Bench for encoder83_rr: round-robin and fixed-priority copies
// share stimulus; delivered codes are checked against queues.
module tb_encoder83_rr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_req;
  logic       i_opt;
  logic       i_ready;

  logic       rr_valid, fp_valid;
  logic [2:0] rr_code, fp_code;
  logic [7:0] rr_pend, fp_pend;
  logic       rr_drop, fp_drop;

  int n_pass = 0;
  int n_total = 0;

  logic [2:0] q_rr[$];
  logic [2:0] q_fp[$];
  logic [2:0] x_rr, x_fp;

  always #5 clk = ~clk;

  encoder83_rr #(.P_EDGE(1'b1), .P_RR(1'b1)) u_rr (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (i_req),
    .i_opt     (i_opt),
    .o_valid   (rr_valid),
    .o_code    (rr_code),
    .i_ready   (i_ready),
    .o_pending (rr_pend),
    .o_drop    (rr_drop)
  );

  encoder83_rr #(.P_EDGE(1'b1), .P_RR(1'b0)) u_fp (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (i_req),
    .i_opt     (i_opt),
    .o_valid   (fp_valid),
    .o_code    (fp_code),
    .i_ready   (i_ready),
    .o_pending (fp_pend),
    .o_drop    (fp_drop)
  );

  always @(negedge clk) begin
    if (rst_n && rr_valid && i_ready) begin
      n_total++;
      if (q_rr.size() == 0) begin
        $display("FAIL rr_unexpected: got code %0d want none", rr_code);
      end else begin
        x_rr = q_rr.pop_front();
        if (rr_code !== x_rr)
          $display("FAIL rr_code: got %0d want %0d", rr_code, x_rr);
        else n_pass++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && fp_valid && i_ready) begin
      n_total++;
      if (q_fp.size() == 0) begin
        $display("FAIL fp_unexpected: got code %0d want none", fp_code);
      end else begin
        x_fp = q_fp.pop_front();
        if (fp_code !== x_fp)
          $display("FAIL fp_code: got %0d want %0d", fp_code, x_fp);
        else n_pass++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_both(input logic [2:0] c);
    q_rr.push_back(c);
    q_fp.push_back(c);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_req = 8'h00; i_opt = 1'b0; i_ready = 1'b1;
    #2;
    n_total++;
    if (rr_valid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", rr_valid);
    else n_pass++;
    n_total++;
    if (rr_code !== 3'd0) $display("FAIL rst_code: got %0d want 0", rr_code);
    else n_pass++;
    n_total++;
    if (rr_pend !== 8'h00) $display("FAIL rst_pend: got %h want 00", rr_pend);
    else n_pass++;
    n_total++;
    if (rr_drop !== 1'b0) $display("FAIL rst_drop: got %0b want 0", rr_drop);
    else n_pass++;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_edge();
    i_opt = 1'b0; i_ready = 1'b1;
    i_req = 8'h08; push_both(3'd3);
    tick(1);
    i_req = 8'h00;
    n_total++;
    if (rr_valid !== 1'b0 || rr_pend !== 8'h08)
      $display("FAIL t1_pend: got v=%0b p=%h want v=0 p=08", rr_valid, rr_pend);
    else n_pass++;
    tick(1);
    n_total++;
    if (rr_valid !== 1'b1 || rr_code !== 3'd3 || rr_pend !== 8'h00)
      $display("FAIL t1_out: got v=%0b c=%0d p=%h want v=1 c=3 p=00",
               rr_valid, rr_code, rr_pend);
    else n_pass++;
    tick(1);
    n_total++;
    if (rr_valid !== 1'b0) $display("FAIL t1_pulse: got v=%0b want 0", rr_valid);
    else n_pass++;
  endtask

  task automatic test_active_low();
    i_opt = 1'b1; i_req = 8'hFF; i_ready = 1'b1;
    tick(3);
    n_total++;
    if (rr_pend !== 8'h00) $display("FAIL t2_idle: got p=%h want 00", rr_pend);
    else n_pass++;
    i_req = 8'hDF; push_both(3'd5);
    tick(6);
    n_total++;
    if (q_rr.size() != 0 || rr_pend !== 8'h00)
      $display("FAIL t2_hold: got left=%0d p=%h want 0 00", q_rr.size(), rr_pend);
    else n_pass++;
    i_req = 8'hFF;
    tick(2);
    i_req = 8'hDF; push_both(3'd5);
    tick(4);
    i_req = 8'h00; i_opt = 1'b0;
    tick(2);
    n_total++;
    if (q_rr.size() != 0 || q_fp.size() != 0)
      $display("FAIL t2_again: got left=%0d/%0d want 0", q_rr.size(), q_fp.size());
    else n_pass++;
  endtask

  task automatic test_stall();
    do_reset();
    i_ready = 1'b0;
    i_req = 8'hA5;
    push_both(3'd0); push_both(3'd2); push_both(3'd5); push_both(3'd7);
    tick(1);
    i_req = 8'h00;
    tick(1);
    n_total++;
    if (rr_valid !== 1'b1 || rr_code !== 3'd0 || rr_pend !== 8'hA4)
      $display("FAIL t3_load: got v=%0b c=%0d p=%h want v=1 c=0 p=a4",
               rr_valid, rr_code, rr_pend);
    else n_pass++;
    tick(3);
    n_total++;
    if (rr_valid !== 1'b1 || rr_code !== 3'd0)
      $display("FAIL t3_hold: got v=%0b c=%0d want v=1 c=0", rr_valid, rr_code);
    else n_pass++;
    i_ready = 1'b1;
    tick(1);
    n_total++;
    if (rr_code !== 3'd2) $display("FAIL t3_b2b2: got %0d want 2", rr_code);
    else n_pass++;
    tick(1);
    n_total++;
    if (rr_code !== 3'd5 || rr_valid !== 1'b1)
      $display("FAIL t3_b2b5: got c=%0d v=%0b want 5 1", rr_code, rr_valid);
    else n_pass++;
    tick(1);
    n_total++;
    if (rr_code !== 3'd7) $display("FAIL t3_b2b7: got %0d want 7", rr_code);
    else n_pass++;
    tick(1);
    n_total++;
    if (rr_valid !== 1'b0) $display("FAIL t3_end: got v=%0b want 0", rr_valid);
    else n_pass++;
  endtask

  task automatic test_fairness();
    i_ready = 1'b1;
    i_req = 8'h81; push_both(3'd0); push_both(3'd7);
    tick(1);
    i_req = 8'h00;
    tick(1);
    n_total++;
    if (rr_code !== 3'd0 || fp_code !== 3'd0)
      $display("FAIL t4_wrap: got rr=%0d fp=%0d want 0 0", rr_code, fp_code);
    else n_pass++;
    tick(1);
    n_total++;
    if (rr_code !== 3'd7 || fp_code !== 3'd7)
      $display("FAIL t4_next: got rr=%0d fp=%0d want 7 7", rr_code, fp_code);
    else n_pass++;
    tick(1);
    i_req = 8'h04; push_both(3'd2);
    tick(1);
    i_req = 8'h00;
    tick(3);
    i_ready = 1'b0;
    i_req = 8'h12;
    tick(1);
    i_req = 8'h00;
    tick(1);
    n_total++;
    if (rr_code !== 3'd4 || fp_code !== 3'd1)
      $display("FAIL t4_pick: got rr=%0d fp=%0d want 4 1", rr_code, fp_code);
    else n_pass++;
    q_rr.push_back(3'd4); q_rr.push_back(3'd1);
    q_fp.push_back(3'd1); q_fp.push_back(3'd4);
    i_ready = 1'b1;
    tick(1);
    n_total++;
    if (rr_code !== 3'd1 || fp_code !== 3'd4)
      $display("FAIL t4_second: got rr=%0d fp=%0d want 1 4", rr_code, fp_code);
    else n_pass++;
    tick(2);
    n_total++;
    if (q_rr.size() != 0 || q_fp.size() != 0 || rr_valid !== 1'b0)
      $display("FAIL t4_done: got left=%0d/%0d v=%0b want 0/0 0",
               q_rr.size(), q_fp.size(), rr_valid);
    else n_pass++;
  endtask

  task automatic test_drop();
    i_ready = 1'b0;
    i_req = 8'h01; push_both(3'd0); push_both(3'd2);
    tick(1);
    i_req = 8'h00;
    tick(1);
    i_req = 8'h04;
    tick(1);
    i_req = 8'h00;
    tick(1);
    i_req = 8'h04;
    tick(1);
    n_total++;
    if (rr_drop !== 1'b1 || fp_drop !== 1'b1 || rr_pend !== 8'h04)
      $display("FAIL t5_drop: got d=%0b/%0b p=%h want 1/1 04",
               rr_drop, fp_drop, rr_pend);
    else n_pass++;
    i_req = 8'h00;
    tick(1);
    n_total++;
    if (rr_drop !== 1'b0) $display("FAIL t5_pulse: got d=%0b want 0", rr_drop);
    else n_pass++;
    i_ready = 1'b1;
    tick(3);
    n_total++;
    if (q_rr.size() != 0 || rr_valid !== 1'b0)
      $display("FAIL t5_once: got left=%0d v=%0b want 0 0", q_rr.size(), rr_valid);
    else n_pass++;
    i_ready = 1'b0;
    i_req = 8'h01;
    push_both(3'd0); push_both(3'd4); push_both(3'd4);
    tick(1);
    i_req = 8'h00;
    tick(1);
    i_req = 8'h10;
    tick(1);
    i_req = 8'h00;
    tick(1);
    i_req = 8'h10; i_ready = 1'b1;
    tick(1);
    n_total++;
    if (rr_code !== 3'd4 || rr_pend !== 8'h10 || rr_drop !== 1'b0)
      $display("FAIL t5_claim: got c=%0d p=%h d=%0b want 4 10 0",
               rr_code, rr_pend, rr_drop);
    else n_pass++;
    i_req = 8'h00;
    tick(1);
    n_total++;
    if (rr_valid !== 1'b1 || rr_code !== 3'd4 || rr_pend !== 8'h00)
      $display("FAIL t5_twice: got v=%0b c=%0d p=%h want 1 4 00",
               rr_valid, rr_code, rr_pend);
    else n_pass++;
    tick(2);
    n_total++;
    if (q_rr.size() != 0 || q_fp.size() != 0)
      $display("FAIL t5_done: got left=%0d/%0d want 0", q_rr.size(), q_fp.size());
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    i_ready = 1'b0;
    i_req = 8'h0E;
    tick(1);
    i_req = 8'h00;
    tick(1);
    n_total++;
    if (rr_valid !== 1'b1 || rr_code !== 3'd1 || rr_pend !== 8'h0C)
      $display("FAIL t6_pre: got v=%0b c=%0d p=%h want 1 1 0c",
               rr_valid, rr_code, rr_pend);
    else n_pass++;
    #1;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (rr_valid !== 1'b0 || rr_pend !== 8'h00 || rr_code !== 3'd0 ||
        fp_valid !== 1'b0 || fp_pend !== 8'h00)
      $display("FAIL t6_async: got v=%0b p=%h c=%0d fv=%0b fp=%h want 0 00 0 0 00",
               rr_valid, rr_pend, rr_code, fp_valid, fp_pend);
    else n_pass++;
    tick(1);
    rst_n = 1'b1; i_ready = 1'b1;
    tick(1);
    i_opt = 1'b1;
    tick(2);
    n_total++;
    if (rr_pend !== 8'h00 || rr_valid !== 1'b0)
      $display("FAIL t6_opt1: got p=%h v=%0b want 00 0", rr_pend, rr_valid);
    else n_pass++;
    i_opt = 1'b0;
    tick(2);
    n_total++;
    if (rr_pend !== 8'h00 || rr_valid !== 1'b0)
      $display("FAIL t6_opt0: got p=%h v=%0b want 00 0", rr_pend, rr_valid);
    else n_pass++;
    i_opt = 1'b1;
    tick(1);
    i_opt = 1'b0;
    tick(3);
    n_total++;
    if (rr_valid !== 1'b0 || fp_valid !== 1'b0 || q_rr.size() != 0)
      $display("FAIL t6_quiet: got v=%0b/%0b left=%0d want 0/0 0",
               rr_valid, fp_valid, q_rr.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_edge();
    test_active_low();
    test_stall();
    test_fairness();
    test_drop();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
